// File: rtl/fp_pkg.sv
// Shared FP32 constants, the unpacked-operand record and the multiplier FSM state type.
package fp_pkg;

  localparam int unsigned FP32_EXP_W   = 8;
  localparam int unsigned FP32_FRAC_W  = 23;
  localparam int          FP32_BIAS    = 127;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
    logic        is_denorm;
  } fp32_unpacked_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_t;

endpackage

// File: rtl/fp32_unpack.sv
// Combinational FP32 unpack: splits a word into sign, effective exponent and significand
// with the hidden bit restored, and classifies zero / inf / NaN / denormal.
module fp32_unpack
  import fp_pkg::*;
(
  input  logic [31:0]    i_word,
  output fp32_unpacked_t o_unp
);

  logic [7:0]  w_exp;
  logic [22:0] w_frac;

  assign w_exp  = i_word[FP32_FRAC_W +: FP32_EXP_W];
  assign w_frac = i_word[FP32_FRAC_W-1:0];

  always_comb begin
    o_unp           = '0;
    o_unp.sign      = i_word[31];
    o_unp.is_zero   = (w_exp == 8'd0) && (w_frac == '0);
    o_unp.is_denorm = (w_exp == 8'd0) && (w_frac != '0);
    o_unp.is_inf    = (w_exp == FP32_EXP_MAX) && (w_frac == '0);
    o_unp.is_nan    = (w_exp == FP32_EXP_MAX) && (w_frac != '0);
    // Denormals (and zero) use an effective exponent of 1 with no hidden bit.
    if (w_exp == 8'd0) begin
      o_unp.exp  = 8'd1;
      o_unp.mant = {1'b0, w_frac};
    end else begin
      o_unp.exp  = w_exp;
      o_unp.mant = {1'b1, w_frac};
    end
  end

endmodule

// File: rtl/fp32_mant_mul_seq.sv
// Sequential FP32 multiply front end: sign, clamped exponent sum, special-case flags and an
// iterative shift-add 24x24 significand product. Define FPMUL_EARLY_TERM_EN for early exit.
module fp32_mant_mul_seq
  import fp_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] out_mant,
  output logic [7:0]  out_exp,
  output logic        out_sign,
  output logic        out_ovf,
  output logic        out_unf,
  output logic        out_zero,
  output logic        out_inf,
  output logic        out_nan
);

  localparam int unsigned NumIter = 24 / BITS_PER_CYCLE;
  localparam int unsigned CntW    = 5;

  fp32_unpacked_t w_ua, w_ub;

  fp32_unpack u_unpack_a (.i_word(a), .o_unp(w_ua));
  fp32_unpack u_unpack_b (.i_word(b), .o_unp(w_ub));

  mul_state_t r_state, w_state_nxt;
  logic [47:0] r_acc, w_acc_nxt;
  logic [23:0] r_ma, w_ma_nxt;
  logic [23:0] r_mb, w_mb_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_exp, w_exp_nxt;
  logic r_sign, w_sign_nxt;
  logic [4:0] r_flags, w_flags_nxt;  // {nan, inf, zero, ovf, unf}

  logic signed [9:0]         w_esum;
  logic [BITS_PER_CYCLE-1:0] w_digit;
  logic [47:0]               w_pp;
  logic                      w_is_nan, w_is_inf, w_is_zero;
  logic                      w_unused;

  assign w_esum = $signed({2'b00, w_ua.exp}) + $signed({2'b00, w_ub.exp}) - 10'(FP32_BIAS);
  assign w_digit = r_mb[23 -: BITS_PER_CYCLE];
  assign w_pp    = 48'(r_ma) * 48'(w_digit);

  assign w_is_nan  = w_ua.is_nan || w_ub.is_nan ||
                     (w_ua.is_inf && w_ub.is_zero) || (w_ua.is_zero && w_ub.is_inf);
  assign w_is_inf  = w_ua.is_inf || w_ub.is_inf;
  assign w_is_zero = w_ua.is_zero || w_ub.is_zero;
  assign w_unused  = w_ua.is_denorm ^ w_ub.is_denorm;

`ifdef FPMUL_EARLY_TERM_EN
  logic [5:0] w_shamt;
  assign w_shamt = 6'(r_cnt * BITS_PER_CYCLE);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_ma_nxt    = r_ma;
    w_mb_nxt    = r_mb;
    w_cnt_nxt   = r_cnt;
    w_exp_nxt   = r_exp;
    w_sign_nxt  = r_sign;
    w_flags_nxt = r_flags;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_sign_nxt  = w_ua.sign ^ w_ub.sign;
          w_acc_nxt   = '0;
          w_flags_nxt = '0;
          w_state_nxt = DONE;
          if (w_is_nan) begin
            w_flags_nxt[4] = 1'b1;
            w_exp_nxt      = FP32_EXP_MAX;
          end else if (w_is_inf) begin
            w_flags_nxt[3] = 1'b1;
            w_exp_nxt      = FP32_EXP_MAX;
          end else if (w_is_zero) begin
            w_flags_nxt[2] = 1'b1;
            w_exp_nxt      = 8'd0;
          end else begin
            if (w_esum >= 10'sd255) begin
              w_exp_nxt      = FP32_EXP_MAX;
              w_flags_nxt[1] = 1'b1;
            end else if (w_esum <= 10'sd0) begin
              w_exp_nxt      = 8'd0;
              w_flags_nxt[0] = 1'b1;
            end else begin
              w_exp_nxt = w_esum[7:0];
            end
            w_ma_nxt    = w_ua.mant;
            w_mb_nxt    = w_ub.mant;
            w_cnt_nxt   = CntW'(NumIter);
            w_state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        w_acc_nxt = (r_acc << BITS_PER_CYCLE) + w_pp;
        w_mb_nxt  = r_mb << BITS_PER_CYCLE;
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CntW'(1)) w_state_nxt = DONE;
`ifdef FPMUL_EARLY_TERM_EN
        // Remaining digits are all zero: apply the outstanding shifts in one step.
        if (r_mb == '0) begin
          w_acc_nxt   = r_acc << w_shamt;
          w_cnt_nxt   = '0;
          w_state_nxt = DONE;
        end
`endif
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_cnt   <= '0;
      r_exp   <= '0;
      r_sign  <= 1'b0;
      r_flags <= '0;
    end else begin
      r_acc   <= w_acc_nxt;
      r_ma    <= w_ma_nxt;
      r_mb    <= w_mb_nxt;
      r_cnt   <= w_cnt_nxt;
      r_exp   <= w_exp_nxt;
      r_sign  <= w_sign_nxt;
      r_flags <= w_flags_nxt;
    end
  end

  assign out_mant = r_acc;
  assign out_exp  = r_exp;
  assign out_sign = r_sign;
  assign out_nan  = r_flags[4];
  assign out_inf  = r_flags[3];
  assign out_zero = r_flags[2];
  assign out_ovf  = r_flags[1];
  assign out_unf  = r_flags[0];

endmodule
